// File: rtl/clock_pkg.sv
// Shared types for the BCD stopwatch time base.
// Digit type, run-state encoding and digit moduli.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DEC_MOD = 10;
  localparam int SEX_MOD = 6;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counter with clear priority over increment.
// Carry is combinational: asserted when incrementing from MAXV.
module bcd_digit_cnt
  import clock_pkg::*;
#(
  parameter int MOD  = DEC_MOD,
  parameter int MAXV = MOD - 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t value_o,
  output logic carry_o
);

  localparam bcd_t MAXB =
    bcd_t'((MAXV < MOD) ? MAXV : MOD - 1);

  bcd_t val_q, val_d;

  // next value: clear, wrap at MAXB, or step
  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i) begin
      val_d = (val_q == MAXB) ? '0 : val_q + 4'd1;
    end
  end

  // digit register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) val_q <= '0;
    else        val_q <= val_d;
  end

  assign value_o = val_q;
  assign carry_o = inc_i && (val_q == MAXB);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.CC stopwatch: run/pause FSM, BCD digit chain, overflow flag.
// Optional lap freeze of the display when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd
  import clock_pkg::*;
#(
  parameter int MIN_MAX = 59
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN10MS,
  input  logic START,
  input  logic CLR,
  input  logic LAP,
  output bcd_t CS0,
  output bcd_t CS1,
  output bcd_t SEC0,
  output bcd_t SEC1,
  output bcd_t MIN0,
  output bcd_t MIN1,
  output logic RUNNING,
  output logic OVF,
  output logic LAP_ACT
);

  localparam bcd_t MMAX1 = bcd_t'(MIN_MAX / 10);
  localparam bcd_t MMAX0 = bcd_t'(MIN_MAX % 10);

  state_t state_q, state_d;
  logic   clr_acc;
  logic   tick;
  logic   wrap;
  logic   clr_all;
  logic   ovf_q, ovf_d;

  bcd_t c0, c1, s0, s1, m0, m1;
  logic c0_cy, c1_cy, s0_cy, s1_cy, m0_cy, m1_cy;
  logic [23:0] live;

  // run/pause/clear decisions; CLR only honoured outside RUN
  always_comb begin
    state_d = state_q;
    clr_acc = 1'b0;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (CLR) begin
          clr_acc = 1'b1;
          state_d = IDLE;
        end else if (START) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (START) state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign tick = (state_q == RUN) && EN10MS;

  assign wrap = tick &&
    (c0 == 4'd9) && (c1 == 4'd9) &&
    (s0 == 4'd9) && (s1 == 4'd5) &&
    (m0 == MMAX0) && (m1 == MMAX1);

  assign clr_all = clr_acc | wrap;

  bcd_digit_cnt #(.MOD(DEC_MOD)) u_cs0 (
    .CLK(CLK), .RST_N(RST_N),
    .inc_i(tick), .clr_i(clr_all),
    .value_o(c0), .carry_o(c0_cy)
  );

  bcd_digit_cnt #(.MOD(DEC_MOD)) u_cs1 (
    .CLK(CLK), .RST_N(RST_N),
    .inc_i(c0_cy), .clr_i(clr_all),
    .value_o(c1), .carry_o(c1_cy)
  );

  bcd_digit_cnt #(.MOD(DEC_MOD)) u_sec0 (
    .CLK(CLK), .RST_N(RST_N),
    .inc_i(c1_cy), .clr_i(clr_all),
    .value_o(s0), .carry_o(s0_cy)
  );

  bcd_digit_cnt #(.MOD(SEX_MOD)) u_sec1 (
    .CLK(CLK), .RST_N(RST_N),
    .inc_i(s0_cy), .clr_i(clr_all),
    .value_o(s1), .carry_o(s1_cy)
  );

  bcd_digit_cnt #(.MOD(DEC_MOD)) u_min0 (
    .CLK(CLK), .RST_N(RST_N),
    .inc_i(s1_cy), .clr_i(clr_all),
    .value_o(m0), .carry_o(m0_cy)
  );

  bcd_digit_cnt #(.MOD(DEC_MOD)) u_min1 (
    .CLK(CLK), .RST_N(RST_N),
    .inc_i(m0_cy), .clr_i(clr_all),
    .value_o(m1), .carry_o(m1_cy)
  );

  // sticky overflow; a 99-minute rollover also counts as a wrap
  always_comb begin
    ovf_d = ovf_q;
    if (clr_acc)             ovf_d = 1'b0;
    else if (wrap || m1_cy)  ovf_d = 1'b1;
  end

  // overflow register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign live    = {m1, m0, s1, s0, c1, c0};
  assign RUNNING = (state_q == RUN);
  assign OVF     = ovf_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_q, lap_d;
  logic [23:0] snap_q, snap_d;

  // lap toggle: freeze only while running, release in RUN or PAUSE
  always_comb begin
    lap_d  = lap_q;
    snap_d = snap_q;
    if (clr_acc) begin
      lap_d  = 1'b0;
      snap_d = '0;
    end else if (LAP) begin
      if (lap_q) begin
        lap_d = 1'b0;
      end else if (state_q == RUN) begin
        lap_d  = 1'b1;
        snap_d = live;
      end
    end
  end

  // lap flag and frozen digits
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lap_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      lap_q  <= lap_d;
      snap_q <= snap_d;
    end
  end

  assign {MIN1, MIN0, SEC1, SEC0, CS1, CS0} =
    lap_q ? snap_q : live;
  assign LAP_ACT = lap_q;
`else
  logic unused_lap;
  assign unused_lap = LAP;
  assign {MIN1, MIN0, SEC1, SEC0, CS1, CS0} = live;
  assign LAP_ACT = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: centisecond-count model plus literal pins.
// Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_bcd;

  localparam int MIN_MAX = 1;
  localparam int LIMIT   = (MIN_MAX + 1) * 6000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic EN10MS = 1'b0;
  logic START = 1'b0;
  logic CLR = 1'b0;
  logic LAP = 1'b0;
  logic [3:0] CS0, CS1, SEC0, SEC1, MIN0, MIN1;
  logic RUNNING, OVF, LAP_ACT;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd #(.MIN_MAX(MIN_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN10MS(EN10MS),
    .START(START), .CLR(CLR), .LAP(LAP),
    .CS0(CS0), .CS1(CS1), .SEC0(SEC0), .SEC1(SEC1),
    .MIN0(MIN0), .MIN1(MIN1),
    .RUNNING(RUNNING), .OVF(OVF), .LAP_ACT(LAP_ACT)
  );

  always #10 CLK = ~CLK;

  // model: total centiseconds, state 0=idle 1=run 2=pause
  int m_t    = 0;
  int m_st   = 0;
  bit m_ovf  = 0;
  bit m_lap  = 0;
  int m_snap = 0;

  function automatic logic [23:0] to_bcd(input int t);
    int mn, sc, cc;
    mn = t / 6000;
    sc = (t / 100) % 60;
    cc = t % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10),
            4'(sc % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_t = 0; m_st = 0; m_ovf = 0; m_lap = 0; m_snap = 0;
    end else if (CLR && m_st != 1) begin
      m_t = 0; m_st = 0; m_ovf = 0; m_lap = 0; m_snap = 0;
    end else begin
      if (LAP_EN && LAP) begin
        if (m_lap) m_lap = 0;
        else if (m_st == 1) begin
          m_lap = 1;
          m_snap = m_t;
        end
      end
      if (m_st == 1 && EN10MS) begin
        if (m_t == LIMIT - 1) begin
          m_t = 0;
          m_ovf = 1;
        end else begin
          m_t = m_t + 1;
        end
      end
      if (START) m_st = (m_st == 1) ? 2 : 1;
    end
  end

  logic [26:0] got_v, exp_v;
  int cyc = 0;

  // per-cycle comparison against the model
  always @(negedge CLK) begin
    cyc++;
    got_v = {MIN1, MIN0, SEC1, SEC0, CS1, CS0, RUNNING, OVF, LAP_ACT};
    exp_v = {to_bcd(m_lap ? m_snap : m_t), m_st == 1, m_ovf, m_lap};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      if (errors < 30)
        $display("FAIL cycle %0d: got %h want %h", cyc, got_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [26:0] got,
                     input logic [26:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [26:0] outs();
    return {MIN1, MIN0, SEC1, SEC0, CS1, CS0, RUNNING, OVF, LAP_ACT};
  endfunction

  task automatic drive(input bit s, input bit c, input bit l,
                       input bit e);
    @(negedge CLK);
    START = s; CLR = c; LAP = l; EN10MS = e;
    @(negedge CLK);
    START = 0; CLR = 0; LAP = 0; EN10MS = 0;
  endtask

  task automatic ticks(input int n);
    @(negedge CLK);
    EN10MS = 1;
    repeat (n) @(negedge CLK);
    EN10MS = 0;
  endtask

  logic [23:0] e_a, e_b, e_c, e_d;

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_state", outs(), {24'h000000, 3'b000});
    RST_N = 1;
    ticks(5);
    chk("idle_ignores_tick", outs(), {24'h000000, 3'b000});

    drive(1, 0, 0, 0);
    chk("start_runs", outs(), {24'h000000, 3'b100});
    ticks(100);
    chk("100_ticks", outs(), {24'h000100, 3'b100});
    drive(0, 1, 0, 0);
    chk("clr_in_run", outs(), {24'h000100, 3'b100});

    ticks(1134);
    chk("at_12_34", outs(), {24'h001234, 3'b100});
    @(negedge CLK);
    #3 RST_N = 0;
    #1 chk("async_reset", outs(), {24'h000000, 3'b000});
    @(negedge CLK);
    RST_N = 1;
    ticks(10);
    chk("post_reset_idle", outs(), {24'h000000, 3'b000});

    drive(1, 0, 0, 0);
    ticks(5999);
    chk("at_59_99", outs(), {24'h005999, 3'b100});
    ticks(1);
    chk("min_carry", outs(), {24'h010000, 3'b100});
    drive(1, 0, 0, 1);
    chk("pause_with_tick", outs(), {24'h010001, 3'b000});
    drive(1, 0, 0, 1);
    chk("resume_no_tick", outs(), {24'h010001, 3'b100});

    ticks(5998);
    chk("at_max", outs(), {24'h015999, 3'b100});
    ticks(1);
    chk("wrap_ovf", outs(), {24'h000000, 3'b110});
    ticks(3);
    chk("ovf_sticky", outs(), {24'h000003, 3'b110});
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("clr_pause", outs(), {24'h000000, 3'b000});

    drive(1, 0, 0, 0);
    ticks(7);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    chk("start_clr_pause", outs(), {24'h000000, 3'b000});
    drive(1, 0, 0, 0);
    ticks(5);
    drive(1, 1, 0, 0);
    chk("start_clr_run", outs(), {24'h000005, 3'b000});
    drive(0, 0, 1, 0);
    chk("lap_in_pause", outs(), {24'h000005, 3'b000});

    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    ticks(500);
    drive(0, 0, 1, 0);
    ticks(300);
    e_a = 24'h000500;
    e_b = 24'h000800;
    e_c = 24'h000800;
    e_d = 24'h000801;
    if (!LAP_EN) begin
      e_a = 24'h000800;
      e_c = 24'h000801;
    end
    chk("lap_frozen", outs(), {e_a, 2'b10, LAP_EN});
    drive(0, 0, 1, 0);
    chk("lap_release", outs(), {e_b, 3'b100});
    drive(0, 0, 1, 1);
    chk("lap_with_tick", outs(), {e_c, 2'b10, LAP_EN});
    drive(0, 0, 1, 0);
    chk("lap_release2", outs(), {e_d, 3'b100});

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
